// File: rtl/uart_ext_pkg.sv
// Shared constants and FSM state types for the uart_ext serial link.
// Both FSMs share one encoding so the debug state outputs read the same way.
package uart_ext_pkg;

   localparam logic [1:0] PAR_NONE = 2'b00;
   localparam logic [1:0] PAR_EVEN = 2'b01;
   localparam logic [1:0] PAR_ODD  = 2'b10;

   typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;

   // Mode 11 is deliberately treated the same as PAR_NONE.
   function automatic logic par_en(input logic [1:0] mode);
      return (mode == PAR_EVEN) || (mode == PAR_ODD);
   endfunction

endpackage

// File: rtl/uart_ext_fifo.sv
// Show-ahead FIFO with registered full/empty flags; the head reads as zero while empty.
// A read and a write in the same cycle on a full FIFO both take effect.
module uart_ext_fifo #(
   parameter int B = 8,
   parameter int W = 4
) (
   input  logic         i_clk,
   input  logic         i_reset,
   input  logic         i_wr,
   input  logic         i_rd,
   input  logic [B-1:0] i_data,
   output logic [B-1:0] o_data,
   output logic         o_full,
   output logic         o_empty
);

   localparam logic [W-1:0] ONE = 1;

   logic [B-1:0] r_mem [0:(1<<W)-1];
   logic [W-1:0] r_wp;
   logic [W-1:0] r_rp;
   logic         r_full;
   logic         r_empty;
   logic         w_push;
   logic         w_pop;

   assign w_pop  = i_rd & ~r_empty;
   assign w_push = i_wr & (~r_full | w_pop);

   always_ff @(posedge i_clk) begin
      if (w_push) r_mem[r_wp] <= i_data;
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_wp    <= '0;
         r_rp    <= '0;
         r_full  <= 1'b0;
         r_empty <= 1'b1;
      end else begin
         if (w_push) r_wp <= r_wp + ONE;
         if (w_pop)  r_rp <= r_rp + ONE;
         if (w_push && !w_pop) begin
            r_empty <= 1'b0;
            r_full  <= ((r_wp + ONE) == r_rp);
         end else if (w_pop && !w_push) begin
            r_full  <= 1'b0;
            r_empty <= ((r_rp + ONE) == r_wp);
         end
      end
   end

   assign o_data  = r_empty ? '0 : r_mem[r_rp];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/uart_ext.sv
// Full-duplex UART, 16x oversampling, run-time divisor, optional parity, 1/2 stop bits.
// Handshake: wr_uart pushes when tx_full=0, rd_uart pops the shown head when rx_empty=0.
module uart_ext
   import uart_ext_pkg::*;
#(
   parameter int DBIT     = 8,
   parameter int FIFO_W   = 4,
   parameter int DVSR_BIT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [DVSR_BIT-1:0] dvsr,
   input  logic [1:0]          par_mode,
   input  logic                stop2,
   input  logic                wr_uart,
   input  logic [DBIT-1:0]     w_data,
   output logic                tx_full,
   output logic                tx_busy,
   output logic                tx,
   input  logic                rx,
   input  logic                rd_uart,
   output logic [DBIT-1:0]     r_data,
   output logic                r_perr,
   output logic                r_ferr,
   output logic                rx_empty,
   output logic                rx_ovr,
   input  logic                clr_ovr,
   output logic [2:0]          dbg_rx_state,
   output logic [2:0]          dbg_tx_state
);

   localparam int NB = $clog2(DBIT);
   localparam logic [NB-1:0]       ONE_N    = 1;
   localparam logic [NB-1:0]       LAST_BIT = NB'(DBIT - 1);
   localparam logic [DVSR_BIT-1:0] ONE_D    = 1;

   // ---------------- tick generator ----------------
   logic [DVSR_BIT-1:0] r_tick_cnt, r_dvsr_q;
   logic                w_tick;

   assign w_tick = (dvsr != '0) && (dvsr == r_dvsr_q) && (r_tick_cnt == dvsr - ONE_D);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tick_cnt <= '0;
         r_dvsr_q   <= '0;
      end else begin
         r_dvsr_q <= dvsr;
         if ((dvsr == '0) || (dvsr != r_dvsr_q) || (r_tick_cnt == dvsr - ONE_D)) r_tick_cnt <= '0;
         else r_tick_cnt <= r_tick_cnt + ONE_D;
      end
   end

   // ---------------- receiver ----------------
   rx_state_t       r_rx_state, w_rx_state_n;
   logic [4:0]      r_rx_s, w_rx_s_n;
   logic [NB-1:0]   r_rx_n, w_rx_n_n;
   logic [DBIT-1:0] r_rx_b, w_rx_b_n;
   logic [1:0]      r_rx_par, w_rx_par_n;
   logic            r_rx_pbit, w_rx_pbit_n, r_rx_stop2, w_rx_stop2_n;
   logic            r_rx_ferr, w_rx_ferr_n, r_rx_perr, w_rx_perr_n;
   logic            r_rx_done, w_rx_done_n, r_rx_ovr;
   logic            w_rx_full;
   logic [DBIT+1:0] w_rx_word;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_rx_state <= RX_IDLE;
         r_rx_s     <= '0;
         r_rx_n     <= '0;
         r_rx_b     <= '0;
         r_rx_par   <= PAR_NONE;
         r_rx_pbit  <= 1'b0;
         r_rx_stop2 <= 1'b0;
         r_rx_ferr  <= 1'b0;
         r_rx_perr  <= 1'b0;
         r_rx_done  <= 1'b0;
      end else begin
         r_rx_state <= w_rx_state_n;
         r_rx_s     <= w_rx_s_n;
         r_rx_n     <= w_rx_n_n;
         r_rx_b     <= w_rx_b_n;
         r_rx_par   <= w_rx_par_n;
         r_rx_pbit  <= w_rx_pbit_n;
         r_rx_stop2 <= w_rx_stop2_n;
         r_rx_ferr  <= w_rx_ferr_n;
         r_rx_perr  <= w_rx_perr_n;
         r_rx_done  <= w_rx_done_n;
      end
   end

   always_comb begin
      w_rx_state_n = r_rx_state;
      w_rx_s_n     = r_rx_s;
      w_rx_n_n     = r_rx_n;
      w_rx_b_n     = r_rx_b;
      w_rx_par_n   = r_rx_par;
      w_rx_pbit_n  = r_rx_pbit;
      w_rx_stop2_n = r_rx_stop2;
      w_rx_ferr_n  = r_rx_ferr;
      w_rx_perr_n  = r_rx_perr;
      w_rx_done_n  = 1'b0;
      case (r_rx_state)
         RX_IDLE: if (!rx) begin
            w_rx_state_n = RX_START;
            w_rx_s_n     = '0;
            w_rx_par_n   = par_mode;
            w_rx_stop2_n = stop2;
            w_rx_ferr_n  = 1'b0;
         end
         RX_START: if (w_tick) begin
            if (r_rx_s == 5'd7) begin
               w_rx_s_n     = '0;
               w_rx_n_n     = '0;
               w_rx_state_n = rx ? RX_IDLE : RX_DATA;
            end else w_rx_s_n = r_rx_s + 5'd1;
         end
         RX_DATA: if (w_tick) begin
            if (r_rx_s == 5'd15) begin
               w_rx_s_n = '0;
               w_rx_b_n = {rx, r_rx_b[DBIT-1:1]};
               if (r_rx_n == LAST_BIT) begin
                  w_rx_n_n     = '0;
                  w_rx_state_n = par_en(r_rx_par) ? RX_PARITY : RX_STOP;
               end else w_rx_n_n = r_rx_n + ONE_N;
            end else w_rx_s_n = r_rx_s + 5'd1;
         end
         RX_PARITY: if (w_tick) begin
            if (r_rx_s == 5'd15) begin
               w_rx_s_n     = '0;
               w_rx_pbit_n  = rx;
               w_rx_state_n = RX_STOP;
            end else w_rx_s_n = r_rx_s + 5'd1;
         end
         RX_STOP: if (w_tick) begin
            if (r_rx_s == 5'd15) begin
               w_rx_s_n    = '0;
               w_rx_ferr_n = r_rx_ferr | ~rx;
               if (r_rx_stop2 && (r_rx_n == '0)) w_rx_n_n = ONE_N;
               else begin
                  w_rx_state_n = RX_IDLE;
                  w_rx_done_n  = 1'b1;
                  w_rx_perr_n  = par_en(r_rx_par) &&
                                 ((^r_rx_b ^ r_rx_pbit) != (r_rx_par == PAR_ODD));
               end
            end else w_rx_s_n = r_rx_s + 5'd1;
         end
         default: w_rx_state_n = RX_IDLE;
      endcase
   end

   // A word finishing into a full FIFO is dropped rather than displacing the head.
   always_ff @(posedge clk) begin
      if (reset) r_rx_ovr <= 1'b0;
      else if (r_rx_done && w_rx_full) r_rx_ovr <= 1'b1;
      else if (clr_ovr) r_rx_ovr <= 1'b0;
   end

   uart_ext_fifo #(.B(DBIT + 2), .W(FIFO_W)) u_rx_fifo (
      .i_clk(clk), .i_reset(reset),
      .i_wr(r_rx_done & ~w_rx_full), .i_rd(rd_uart),
      .i_data({r_rx_ferr, r_rx_perr, r_rx_b}),
      .o_data(w_rx_word), .o_full(w_rx_full), .o_empty(rx_empty)
   );

   assign r_data       = w_rx_word[DBIT-1:0];
   assign r_perr       = w_rx_word[DBIT];
   assign r_ferr       = w_rx_word[DBIT+1];
   assign rx_ovr       = r_rx_ovr;
   assign dbg_rx_state = r_rx_state;

   // ---------------- transmitter ----------------
   tx_state_t       r_tx_state, w_tx_state_n;
   logic [4:0]      r_tx_s, w_tx_s_n;
   logic [NB-1:0]   r_tx_n, w_tx_n_n;
   logic [DBIT-1:0] r_tx_b, w_tx_b_n;
   logic            r_tx_pbit, w_tx_pbit_n, r_tx_paren, w_tx_paren_n;
   logic            r_tx_stop2, w_tx_stop2_n, r_tx, w_tx_n;
   logic            w_tx_pop, w_tx_empty;
   logic [DBIT-1:0] w_tx_head;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_tx_state <= TX_IDLE;
         r_tx_s     <= '0;
         r_tx_n     <= '0;
         r_tx_b     <= '0;
         r_tx_pbit  <= 1'b0;
         r_tx_paren <= 1'b0;
         r_tx_stop2 <= 1'b0;
         r_tx       <= 1'b1;
      end else begin
         r_tx_state <= w_tx_state_n;
         r_tx_s     <= w_tx_s_n;
         r_tx_n     <= w_tx_n_n;
         r_tx_b     <= w_tx_b_n;
         r_tx_pbit  <= w_tx_pbit_n;
         r_tx_paren <= w_tx_paren_n;
         r_tx_stop2 <= w_tx_stop2_n;
         r_tx       <= w_tx_n;
      end
   end

   always_comb begin
      w_tx_state_n = r_tx_state;
      w_tx_s_n     = r_tx_s;
      w_tx_n_n     = r_tx_n;
      w_tx_b_n     = r_tx_b;
      w_tx_pbit_n  = r_tx_pbit;
      w_tx_paren_n = r_tx_paren;
      w_tx_stop2_n = r_tx_stop2;
      w_tx_pop     = 1'b0;
      case (r_tx_state)
         TX_IDLE: if (!w_tx_empty && (dvsr != '0)) begin
            w_tx_state_n = TX_START;
            w_tx_s_n     = '0;
            w_tx_b_n     = w_tx_head;
            w_tx_pbit_n  = ^w_tx_head ^ (par_mode == PAR_ODD);
            w_tx_paren_n = par_en(par_mode);
            w_tx_stop2_n = stop2;
            w_tx_pop     = 1'b1;
         end
         TX_START: if (w_tick) begin
            if (r_tx_s == 5'd15) begin
               w_tx_s_n     = '0;
               w_tx_n_n     = '0;
               w_tx_state_n = TX_DATA;
            end else w_tx_s_n = r_tx_s + 5'd1;
         end
         TX_DATA: if (w_tick) begin
            if (r_tx_s == 5'd15) begin
               w_tx_s_n = '0;
               w_tx_b_n = r_tx_b >> 1;
               if (r_tx_n == LAST_BIT) w_tx_state_n = r_tx_paren ? TX_PARITY : TX_STOP;
               else w_tx_n_n = r_tx_n + ONE_N;
            end else w_tx_s_n = r_tx_s + 5'd1;
         end
         TX_PARITY: if (w_tick) begin
            if (r_tx_s == 5'd15) begin
               w_tx_s_n     = '0;
               w_tx_state_n = TX_STOP;
            end else w_tx_s_n = r_tx_s + 5'd1;
         end
         TX_STOP: if (w_tick) begin
            if (r_tx_s == (r_tx_stop2 ? 5'd31 : 5'd15)) w_tx_state_n = TX_IDLE;
            else w_tx_s_n = r_tx_s + 5'd1;
         end
         default: w_tx_state_n = TX_IDLE;
      endcase
      // Line level is registered from the next state so the pin never glitches.
      case (w_tx_state_n)
         TX_START:  w_tx_n = 1'b0;
         TX_DATA:   w_tx_n = w_tx_b_n[0];
         TX_PARITY: w_tx_n = w_tx_pbit_n;
         default:   w_tx_n = 1'b1;
      endcase
   end

   uart_ext_fifo #(.B(DBIT), .W(FIFO_W)) u_tx_fifo (
      .i_clk(clk), .i_reset(reset),
      .i_wr(wr_uart), .i_rd(w_tx_pop), .i_data(w_data),
      .o_data(w_tx_head), .o_full(tx_full), .o_empty(w_tx_empty)
   );

   assign tx           = r_tx;
   assign tx_busy      = (r_tx_state != TX_IDLE) | ~w_tx_empty;
   assign dbg_tx_state = r_tx_state;

endmodule

// File: tb/tb_uart_ext.sv
// Scenario bench for uart_ext at dvsr=4 (64 clk per bit); received words are checked
// against an expected queue filled when each frame is launched.
module tb_uart_ext;

   logic        clk = 1'b0;
   logic        reset, stop2, wr_uart, rd_uart, clr_ovr;
   logic [15:0] dvsr;
   logic [1:0]  par_mode;
   logic [7:0]  w_data, r_data;
   logic        tx_full, tx_busy, tx, rx, r_perr, r_ferr, rx_empty, rx_ovr;
   logic [2:0]  dbg_rx_state, dbg_tx_state;
   logic        loop_en, rx_drv;

   logic [9:0]  exp_q[$];
   int          n_cmp = 0;
   int          n_bad = 0;

   always #5 clk = ~clk;
   assign rx = loop_en ? tx : rx_drv;

   uart_ext #(.DBIT(8), .FIFO_W(4), .DVSR_BIT(16)) dut (
      .clk(clk), .reset(reset), .dvsr(dvsr), .par_mode(par_mode), .stop2(stop2),
      .wr_uart(wr_uart), .w_data(w_data), .tx_full(tx_full), .tx_busy(tx_busy), .tx(tx),
      .rx(rx), .rd_uart(rd_uart), .r_data(r_data), .r_perr(r_perr), .r_ferr(r_ferr),
      .rx_empty(rx_empty), .rx_ovr(rx_ovr), .clr_ovr(clr_ovr),
      .dbg_rx_state(dbg_rx_state), .dbg_tx_state(dbg_tx_state)
   );

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at %0t", $time);
      $fatal(1);
   end

   // ---------------- driver tasks ----------------
   task automatic push_tx(input logic [7:0] d);
      wr_uart = 1'b1;
      w_data  = d;
      @(negedge clk);
      wr_uart = 1'b0;
   endtask

   task automatic rx_stop_bit(input logic v);
      // A low stop bit is released early so the receiver sees the line high again
      // before it re-checks a would-be start bit.
      rx_drv = v;
      repeat (v ? 64 : 40) @(negedge clk);
      rx_drv = 1'b1;
      repeat (v ? 0 : 24) @(negedge clk);
   endtask

   task automatic drive_rx(input logic [7:0] d, input logic has_par, input logic pbit,
                           input logic sb1, input logic two_stop, input logic sb2);
      rx_drv = 1'b0;
      repeat (64) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx_drv = d[i];
         repeat (64) @(negedge clk);
      end
      if (has_par) begin
         rx_drv = pbit;
         repeat (64) @(negedge clk);
      end
      rx_stop_bit(sb1);
      if (two_stop) rx_stop_bit(sb2);
      rx_drv = 1'b1;
      repeat (64) @(negedge clk);
   endtask

   task automatic capture_tx(input int nbits, output logic [11:0] bits, output int low_len,
                             output logic ok);
      logic seen;
      bits    = '0;
      low_len = -1;
      seen    = 1'b0;
      for (int i = 0; i < 3000 && tx !== 1'b0; i++) @(negedge clk);
      ok = (tx === 1'b0);
      if (ok) begin
         for (int c = 0; c <= 32 + 64 * (nbits - 1); c++) begin
            if (!seen && tx === 1'b1) begin
               low_len = c;
               seen    = 1'b1;
            end
            if (c >= 32 && ((c - 32) % 64) == 0) bits[(c - 32) / 64] = tx;
            @(negedge clk);
         end
      end
   endtask

   task automatic rx_pop(output logic [9:0] word, output logic ok);
      for (int i = 0; i < 3000 && rx_empty; i++) @(negedge clk);
      ok   = !rx_empty;
      word = {r_ferr, r_perr, r_data};
      if (ok) begin
         rd_uart = 1'b1;
         @(negedge clk);
         rd_uart = 1'b0;
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++; if (tx !== 1'b1) begin n_bad++; $display("FAIL reset_tx: got %b want 1", tx); end
      n_cmp++; if (tx_busy !== 1'b0) begin n_bad++; $display("FAIL reset_tx_busy: got %b want 0", tx_busy); end
      n_cmp++; if (tx_full !== 1'b0) begin n_bad++; $display("FAIL reset_tx_full: got %b want 0", tx_full); end
      n_cmp++; if (rx_empty !== 1'b1) begin n_bad++; $display("FAIL reset_rx_empty: got %b want 1", rx_empty); end
      n_cmp++; if (rx_ovr !== 1'b0) begin n_bad++; $display("FAIL reset_rx_ovr: got %b want 0", rx_ovr); end
      n_cmp++; if ({r_ferr, r_perr, r_data} !== 10'h000) begin
         n_bad++; $display("FAIL reset_r_word: got %h want 000", {r_ferr, r_perr, r_data});
      end
      n_cmp++; if ({dbg_rx_state, dbg_tx_state} !== 6'o00) begin
         n_bad++; $display("FAIL reset_states: got %o want 00", {dbg_rx_state, dbg_tx_state});
      end
      reset = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_8n1;
      logic [11:0] bits, exp_bits;
      logic [9:0]  got, exp;
      int          low_len;
      logic        ok;
      loop_en = 1'b1;
      exp_q.push_back({2'b00, 8'hA5});
      push_tx(8'hA5);
      capture_tx(10, bits, low_len, ok);
      exp_bits = {2'b00, 1'b1, 8'hA5, 1'b0};
      n_cmp++; if (!ok || bits !== exp_bits) begin
         n_bad++; $display("FAIL 8n1_tx_frame: got %b want %b", bits, exp_bits);
      end
      // The first bit may be up to one tick period short depending on tick phase.
      n_cmp++; if (low_len < 61 || low_len > 64) begin
         n_bad++; $display("FAIL 8n1_start_len: got %0d want 61..64", low_len);
      end
      rx_pop(got, ok);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || got !== exp) begin
         n_bad++; $display("FAIL 8n1_rx_word: got %h (ok=%b) want %h", got, ok, exp);
      end
      repeat (100) @(negedge clk);
   endtask

   task automatic test_parity;
      logic [11:0] bits, exp_bits;
      logic [9:0]  got, exp;
      int          low_len;
      logic        ok;
      loop_en  = 1'b0;
      rx_drv   = 1'b1;
      par_mode = 2'b01;
      push_tx(8'h07);
      capture_tx(11, bits, low_len, ok);
      exp_bits = {1'b0, 1'b1, 1'b1, 8'h07, 1'b0};
      n_cmp++; if (!ok || bits[9] !== 1'b1) begin
         n_bad++; $display("FAIL even_tx_pbit: got %b want 1", bits[9]);
      end
      n_cmp++; if (bits !== exp_bits) begin
         n_bad++; $display("FAIL even_tx_frame: got %b want %b", bits, exp_bits);
      end
      repeat (100) @(negedge clk);
      // Even mode, parity bit forced 0 on a word with three ones.
      exp_q.push_back({1'b0, ((^8'h07) ^ 1'b0) != 1'b0, 8'h07});
      drive_rx(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      rx_pop(got, ok);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || got !== exp) begin
         n_bad++; $display("FAIL even_rx_perr: got %h (ok=%b) want %h", got, ok, exp);
      end
      par_mode = 2'b10;
      exp_q.push_back({1'b0, ((^8'h07) ^ 1'b0) != 1'b1, 8'h07});
      drive_rx(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
      rx_pop(got, ok);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || got !== exp) begin
         n_bad++; $display("FAIL odd_rx_ok: got %h (ok=%b) want %h", got, ok, exp);
      end
      par_mode = 2'b00;
   endtask

   task automatic test_framing;
      logic [9:0] got, exp;
      logic       ok;
      loop_en = 1'b0;
      exp_q.push_back({2'b10, 8'h3C});
      drive_rx(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      rx_pop(got, ok);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || got !== exp) begin
         n_bad++; $display("FAIL ferr_1stop: got %h (ok=%b) want %h", got, ok, exp);
      end
      stop2 = 1'b1;
      exp_q.push_back({2'b10, 8'h3C});
      drive_rx(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      rx_pop(got, ok);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || got !== exp) begin
         n_bad++; $display("FAIL ferr_2nd_stop: got %h (ok=%b) want %h", got, ok, exp);
      end
      stop2 = 1'b0;
      repeat (200) @(negedge clk);
      n_cmp++; if (rx_empty !== 1'b1) begin
         n_bad++; $display("FAIL ferr_no_extra_word: rx_empty got %b want 1", rx_empty);
      end
   endtask

   task automatic test_glitch;
      loop_en = 1'b0;
      rx_drv  = 1'b0;
      repeat (10) @(negedge clk);
      n_cmp++; if (dbg_rx_state !== 3'd1) begin
         n_bad++; $display("FAIL glitch_start: rx state got %0d want 1", dbg_rx_state);
      end
      repeat (10) @(negedge clk);
      rx_drv = 1'b1;
      repeat (150) @(negedge clk);
      n_cmp++; if (dbg_rx_state !== 3'd0) begin
         n_bad++; $display("FAIL glitch_idle: rx state got %0d want 0", dbg_rx_state);
      end
      n_cmp++; if (rx_empty !== 1'b1) begin
         n_bad++; $display("FAIL glitch_no_word: rx_empty got %b want 1", rx_empty);
      end
   endtask

   task automatic test_overrun;
      logic [9:0] got, exp;
      logic       ok;
      loop_en = 1'b0;
      for (int i = 0; i <= 16; i++) begin
         if (i < 16) exp_q.push_back({2'b00, 8'(i)});
         drive_rx(8'(i), 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
      end
      repeat (20) @(negedge clk);
      n_cmp++; if (rx_ovr !== 1'b1) begin
         n_bad++; $display("FAIL ovr_set: rx_ovr got %b want 1", rx_ovr);
      end
      for (int i = 0; i < 16; i++) begin
         rx_pop(got, ok);
         exp = exp_q.pop_front();
         n_cmp++; if (!ok || got !== exp) begin
            n_bad++; $display("FAIL ovr_word%0d: got %h (ok=%b) want %h", i, got, ok, exp);
         end
      end
      n_cmp++; if (rx_empty !== 1'b1) begin
         n_bad++; $display("FAIL ovr_17th_lost: rx_empty got %b want 1", rx_empty);
      end
      clr_ovr = 1'b1;
      @(negedge clk);
      clr_ovr = 1'b0;
      n_cmp++; if (rx_ovr !== 1'b0) begin
         n_bad++; $display("FAIL ovr_clear: rx_ovr got %b want 0", rx_ovr);
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] got, exp;
      logic [7:0] d;
      logic       ok;
      loop_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         d = 8'($urandom_range(0, 255));
         exp_q.push_back({2'b00, d});
         push_tx(d);
      end
      n_cmp++; if (tx_busy !== 1'b1) begin
         n_bad++; $display("FAIL b2b_busy: tx_busy got %b want 1", tx_busy);
      end
      for (int i = 0; i < 3; i++) begin
         rx_pop(got, ok);
         exp = exp_q.pop_front();
         n_cmp++; if (!ok || got !== exp) begin
            n_bad++; $display("FAIL b2b_word%0d: got %h (ok=%b) want %h", i, got, ok, exp);
         end
      end
      repeat (100) @(negedge clk);
      n_cmp++; if (tx_busy !== 1'b0) begin
         n_bad++; $display("FAIL b2b_idle: tx_busy got %b want 0", tx_busy);
      end
   endtask

   task automatic test_tx_full;
      dvsr = 16'd0;
      @(negedge clk);
      for (int i = 0; i < 17; i++) push_tx(8'(8'h80 + i));
      @(negedge clk);
      n_cmp++; if (tx_full !== 1'b1) begin
         n_bad++; $display("FAIL txfull_set: tx_full got %b want 1", tx_full);
      end
      repeat (100) @(negedge clk);
      n_cmp++; if ({tx, tx_busy, dbg_tx_state} !== {1'b1, 1'b1, 3'd0}) begin
         n_bad++; $display("FAIL txfull_halted: tx/busy/state got %b want 11000", {tx, tx_busy, dbg_tx_state});
      end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      dvsr  = 16'd4;
      @(negedge clk);
      n_cmp++; if ({tx_full, tx_busy} !== 2'b00) begin
         n_bad++; $display("FAIL txfull_flushed: full/busy got %b want 00", {tx_full, tx_busy});
      end
   endtask

   task automatic test_reset_mid;
      logic [11:0] bits, exp_bits;
      logic [9:0]  got, exp;
      int          low_len;
      logic        ok;
      loop_en = 1'b1;
      push_tx(8'hFF);
      for (int i = 0; i < 3000 && tx !== 1'b0; i++) @(negedge clk);
      repeat (64 * 4 + 32) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if ({tx, tx_busy, rx_empty} !== 3'b101) begin
         n_bad++; $display("FAIL rstmid_flags: tx/busy/rx_empty got %b want 101", {tx, tx_busy, rx_empty});
      end
      reset = 1'b0;
      exp_q.delete();
      repeat (4) @(negedge clk);
      exp_q.push_back({2'b00, 8'h55});
      push_tx(8'h55);
      capture_tx(10, bits, low_len, ok);
      exp_bits = {2'b00, 1'b1, 8'h55, 1'b0};
      n_cmp++; if (!ok || bits !== exp_bits) begin
         n_bad++; $display("FAIL rstmid_tx_frame: got %b want %b", bits, exp_bits);
      end
      rx_pop(got, ok);
      exp = exp_q.pop_front();
      n_cmp++; if (!ok || got !== exp) begin
         n_bad++; $display("FAIL rstmid_rx_word: got %h (ok=%b) want %h", got, ok, exp);
      end
      repeat (100) @(negedge clk);
   endtask

   initial begin
      reset    = 1'b1;
      dvsr     = 16'd4;
      par_mode = 2'b00;
      stop2    = 1'b0;
      wr_uart  = 1'b0;
      w_data   = 8'h00;
      rd_uart  = 1'b0;
      clr_ovr  = 1'b0;
      loop_en  = 1'b1;
      rx_drv   = 1'b1;
      @(negedge clk);
      test_reset;
      test_8n1;
      test_parity;
      test_framing;
      test_glitch;
      test_overrun;
      test_back_to_back;
      test_tx_full;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
